// File: rtl/pc_fetch_unit_if.sv
// Fetch-side bundle: redirect/handshake inputs from decode/execute, fetch address and counters back.
interface pc_fetch_unit_if;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned OFF_W = 16;
  localparam int unsigned IDX_W = 26;

  logic             fetch_ready;
  logic             br_taken;
  logic             jump;
  logic [XLEN-1:0]  redir_base;
  logic [OFF_W-1:0] br_offset;
  logic [IDX_W-1:0] jump_index;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_plus4;
  logic             fetch_valid;
  logic [XLEN-1:0]  fetch_count;

  // Master is the fetch unit itself; slave is the memory/decode side.
  modport master (
    input  fetch_ready, br_taken, jump, redir_base, br_offset, jump_index,
    output pc, pc_plus4, fetch_valid, fetch_count
  );

  modport slave (
    output fetch_ready, br_taken, jump, redir_base, br_offset, jump_index,
    input  pc, pc_plus4, fetch_valid, fetch_count
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter / fetch request generator with branch and jump redirect,
// one-cycle bubble after every redirect, and an accepted-fetch counter.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  pc_fetch_unit_if.master bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OFF_W = 16;
  localparam int unsigned IDX_W = 26;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    BUBBLE = 2'd2
  } state_e;

  state_e            state_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   fetch_count_q;
  logic              fetch_valid_q;

  logic              redirect;
  logic              accept;
  logic [XLEN-1:0]   off_sext;
  logic [XLEN-1:0]   br_target;
  logic [XLEN-1:0]   jmp_target;
  logic [XLEN-1:0]   redir_target;

  assign redirect = bus.jump | bus.br_taken;
  assign accept   = fetch_valid_q & bus.fetch_ready;

  // Redirect target selection: jump has priority over a taken branch.
  always_comb begin
    off_sext     = {{(XLEN-OFF_W){bus.br_offset[OFF_W-1]}}, bus.br_offset};
    br_target    = bus.redir_base + (off_sext << 2);
    jmp_target   = {bus.redir_base[XLEN-1:XLEN-4], bus.jump_index, 2'b00};
    redir_target = bus.jump ? jmp_target : br_target;
  end

  // Single-process FSM; a redirect overrides whatever the current state would do.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      fetch_count_q <= '0;
    end else if (redirect) begin
      state_q       <= BUBBLE;
      pc_q          <= {redir_target[XLEN-1:2], 2'b00};
      fetch_valid_q <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q       <= FETCH;
          fetch_valid_q <= 1'b1;
        end
        FETCH: begin
          fetch_valid_q <= 1'b1;
          if (accept) begin
            pc_q          <= pc_q + XLEN'(4);
            fetch_count_q <= fetch_count_q + XLEN'(1);
          end
        end
        BUBBLE: begin
          state_q       <= FETCH;
          fetch_valid_q <= 1'b1;
        end
        default: begin
          state_q       <= BOOT;
          fetch_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // During reset the incrementer shows the reset vector so downstream sees a sane value.
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = rst ? (RESET_VECTOR + XLEN'(4)) : (pc_q + XLEN'(4));
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_count = fetch_count_q;

  a_pc_aligned : assert property (@(posedge clk) disable iff (rst) pc_q[1:0] == 2'b00);
  a_valid_fetch : assert property (@(posedge clk) disable iff (rst)
                                   fetch_valid_q == (state_q == FETCH));

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Random and directed stimulus for pc_fetch_unit checked against a stateless-style reference model.
module tb_pc_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst_b;

  pc_fetch_unit_if bus ();
  pc_fetch_unit_if bus_b ();

  pc_fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  pc_fetch_unit #(.RESET_VECTOR(32'hFFFF_FFF8)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b.master)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: a fetch address, whether it is being offered, and an accepted count.
  logic [31:0] m_pc    = 32'h0;
  logic        m_valid = 1'b0;
  logic [31:0] m_cnt   = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [31:0] tgt;
    if (rst) begin
      m_pc    = 32'h0;
      m_valid = 1'b0;
      m_cnt   = 32'h0;
    end else if (bus.jump || bus.br_taken) begin
      if (bus.jump)
        tgt = {bus.redir_base[31:28], bus.jump_index, 2'b00};
      else
        tgt = bus.redir_base + 32'($signed(bus.br_offset)) * 32'd4;
      m_pc    = tgt;
      m_valid = 1'b0;
    end else if (!m_valid) begin
      m_valid = 1'b1;
    end else if (bus.fetch_ready) begin
      m_pc  = m_pc + 32'd4;
      m_cnt = m_cnt + 32'd1;
    end
  endtask

  task automatic check_all();
    check_eq("pc", bus.pc, m_pc);
    check_eq("fetch_valid", 32'(bus.fetch_valid), 32'(m_valid));
    check_eq("fetch_count", bus.fetch_count, m_cnt);
    check_eq("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
  endtask

  task automatic step(input logic r, input logic fr, input logic bt, input logic jp,
                      input logic [31:0] base, input logic [15:0] off, input logic [25:0] idx);
    @(negedge clk);
    rst             = r;
    bus.fetch_ready = fr;
    bus.br_taken    = bt;
    bus.jump        = jp;
    bus.redir_base  = base;
    bus.br_offset   = off;
    bus.jump_index  = idx;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input logic fr);
    step(1'b0, fr, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
  endtask

  initial begin
    rst              = 1'b1;
    rst_b            = 1'b1;
    bus.fetch_ready  = 1'b0;
    bus.br_taken     = 1'b0;
    bus.jump         = 1'b0;
    bus.redir_base   = 32'h0;
    bus.br_offset    = 16'h0;
    bus.jump_index   = 26'h0;
    bus_b.fetch_ready = 1'b0;
    bus_b.br_taken    = 1'b0;
    bus_b.jump        = 1'b0;
    bus_b.redir_base  = 32'h0;
    bus_b.br_offset   = 16'h0;
    bus_b.jump_index  = 26'h0;

    #1;
    check_eq("pc_plus4_in_reset", bus.pc_plus4, 32'h0000_0004);

    // Reset, boot bubble, then four accepted sequential fetches.
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
    check_eq("reset_pc", bus.pc, 32'h0);
    check_eq("reset_valid", 32'(bus.fetch_valid), 32'h0);
    idle(1'b1);
    check_eq("boot_then_valid", 32'(bus.fetch_valid), 32'h1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    check_eq("seq_count4", bus.fetch_count, 32'd4);
    check_eq("seq_pc16", bus.pc, 32'd16);

    // Stall at pc=8 for three cycles.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      check_eq("stall_pc", bus.pc, 32'h8);
      check_eq("stall_valid", 32'(bus.fetch_valid), 32'h1);
      check_eq("stall_count", bus.fetch_count, 32'd2);
    end

    // Backward branch squashes the presented fetch even with ready high.
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 16'hFFFE, 26'h0);
    check_eq("br_pc", bus.pc, 32'h8);
    check_eq("br_bubble", 32'(bus.fetch_valid), 32'h0);
    check_eq("br_squash_count", bus.fetch_count, 32'd2);
    idle(1'b1);
    check_eq("br_n2_valid", 32'(bus.fetch_valid), 32'h1);
    idle(1'b1);

    // Jump beats branch in the same cycle.
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h4000_0100, 16'h0123, 26'h000_0040);
    check_eq("jump_wins_pc", bus.pc, 32'h4000_0100);
    // Redirect again while in the bubble: stays invalid one more cycle.
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 16'h0004, 26'h0);
    check_eq("bubble_redir_pc", bus.pc, 32'h0000_1010);
    check_eq("bubble_redir_valid", 32'(bus.fetch_valid), 32'h0);
    // Reset during bubble with a redirect pending.
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 16'h0, 26'h3FF_FFFF);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 16'h0, 26'h3FF_FFFF);
    check_eq("rst_bubble_pc", bus.pc, 32'h0);
    check_eq("rst_bubble_count", bus.fetch_count, 32'h0);
    idle(1'b1);
    check_eq("rst_boot_then_pc", bus.pc, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 32) == 0, ($urandom % 2) == 0, ($urandom % 6) == 0,
           ($urandom % 8) == 0, $urandom & 32'hFFFF_FFFC, 16'($urandom),
           26'($urandom));
    end

    // Wrap-around from the high reset vector.
    @(negedge clk);
    check_eq("wrap_rst_pc", bus_b.pc, 32'hFFFF_FFF8);
    check_eq("wrap_rst_plus4", bus_b.pc_plus4, 32'hFFFF_FFFC);
    rst_b             = 1'b0;
    bus_b.fetch_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("wrap_pc0", bus_b.pc, 32'hFFFF_FFF8);
    check_eq("wrap_valid", 32'(bus_b.fetch_valid), 32'h1);
    @(posedge clk); #1;
    check_eq("wrap_pc1", bus_b.pc, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    check_eq("wrap_pc2", bus_b.pc, 32'h0000_0000);
    check_eq("wrap_count", bus_b.fetch_count, 32'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
